// File: rtl/wb_hp_host.sv
// wb_hp_host: single-outstanding Wishbone pipelined initiator with ack timeout
module wb_hp_host #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_hp_host: TIMEOUT must be in 2..255");
  end
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_cyc, r_stb, r_we, r_rsp_valid, r_err;
  logic [31:0] r_addr, r_data, r_rsp_data;
  logic        w_accept, w_ack, w_to;
  // an ack only counts once the strobe is (or has been) accepted
  always_comb begin
    w_accept = (r_state == REQ) && !i_wb_stall;
    w_ack    = (r_state == REQ) ? (w_accept && i_wb_ack) : (r_state == WAIT) && i_wb_ack;
    w_to     = (r_state == REQ || r_state == WAIT) && !w_ack && (r_cnt == 8'(TIMEOUT - 1));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_cmd_valid) begin
          r_we    <= i_cmd_we;
          r_addr  <= i_cmd_addr;
          r_data  <= i_cmd_data;
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_cnt   <= '0;
          r_state <= REQ;
        end
        REQ, WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_ack || w_to) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_err       <= w_to;
            r_rsp_data  <= (w_ack && !r_we) ? i_wb_data : '0;
            r_state     <= RESP;
          end else if (w_accept) begin
            r_stb   <= 1'b0;
            r_state <= WAIT;
          end
        end
        RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_cmd_ready = (r_state == IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_err;
  assign o_rsp_data  = r_rsp_data;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_data;
endmodule
